// File: rtl/mult_iter_unit.sv
// Iterative radix-2 shift-add 32x32 multiplier with signed/unsigned support.
// Optional MULT_EARLY_TERM_EN stops the loop once the remaining multiplier is zero.
module mult_iter_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             mult_sign,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       mcand_q, mcand_d;
  logic [WIDTH-1:0]       mplier_q, mplier_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [2*WIDTH-1:0]     prod_q, prod_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   neg_q, neg_d;

  logic [WIDTH-1:0]       mag_a, mag_b;
  logic [2*WIDTH-1:0]     acc_sum;
  logic                   last_iter;

  always_comb begin
    mag_a = (mult_sign && op_a[WIDTH-1]) ? (~op_a + WIDTH'(1)) : op_a;
    mag_b = (mult_sign && op_b[WIDTH-1]) ? (~op_b + WIDTH'(1)) : op_b;
    acc_sum = acc_q + (mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0);
`ifdef MULT_EARLY_TERM_EN
    // Done once no set bits remain above the one consumed this cycle.
    last_iter = (cnt_q == CNT_W'(WIDTH - 1)) || (mplier_q[WIDTH-1:1] == '0);
`else
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`endif
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start_mult) begin
          state_d  = StCalc;
          mcand_d  = mag_a;
          mplier_d = mag_b;
          neg_d    = mult_sign & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      StCalc: begin
        acc_d    = acc_sum;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d = StDone;
          prod_d  = neg_q ? (~acc_sum + (2*WIDTH)'(1)) : acc_sum;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end

  assign busy    = (state_q == StCalc);
  assign done    = (state_q == StDone);
  assign prod_hi = prod_q[2*WIDTH-1:WIDTH];
  assign prod_lo = prod_q[WIDTH-1:0];

endmodule

// File: tb/tb_mult_iter_unit.sv
// Self-checking bench for mult_iter_unit: vector table, corner sequences and random
// operands against an arithmetic reference model.
module tb_mult_iter_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_mult;
  logic        mult_sign;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] prod_hi, prod_lo;

  int n_checks = 0;
  int n_fail   = 0;

  mult_iter_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .mult_sign  (mult_sign),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .prod_hi    (prod_hi),
    .prod_lo    (prod_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'h0, a} * {32'h0, b};
  endfunction

  // Edges from acceptance (inclusive) until done is visible.
  function automatic int exp_lat(input logic s, input logic [31:0] b);
`ifdef MULT_EARLY_TERM_EN
    logic [31:0] m;
    int it;
    m  = (s && b[31]) ? -b : b;
    it = 1;
    for (int i = 0; i < 32; i++) if (m[i]) it = i + 1;
    return it + 1;
`else
    return 33;
`endif
  endfunction

  task automatic run_mult(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [63:0] prod);
    start_mult = 1'b1;
    mult_sign  = s;
    op_a       = a;
    op_b       = b;
    @(posedge clk); #1;
    start_mult = 1'b0;
    op_a       = $urandom;
    op_b       = $urandom;
    mult_sign  = $urandom_range(0, 1);
    lat = 1;
    check("busy_after_accept", {63'h0, busy}, 64'h1);
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    prod = {prod_hi, prod_lo};
  endtask

  vec_t        vecs[8];
  int          lat;
  logic [63:0] prod, last_exp;
  logic [31:0] ra, rb;
  logic        rs;

  initial begin
    vecs[0] = '{1'b0, 32'h00000003, 32'h00000005, 64'h00000000_0000000F};
    vecs[1] = '{1'b1, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1};
    vecs[2] = '{1'b0, 32'hFFFFFFFD, 32'h00000005, 64'h00000004_FFFFFFF1};
    vecs[3] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    vecs[4] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};
    vecs[5] = '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    vecs[6] = '{1'b0, 32'h00000007, 32'h00000006, 64'h00000000_0000002A};
    vecs[7] = '{1'b1, 32'h00000000, 32'h00012345, 64'h0};

    reset = 1'b0; start_mult = 1'b0; mult_sign = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_done", {63'h0, done}, 64'h0);
    check("reset_prod", {prod_hi, prod_lo}, 64'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_mult(vecs[i].s, vecs[i].a, vecs[i].b, lat, prod);
      check($sformatf("vec%0d_prod", i), prod, vecs[i].exp);
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(exp_lat(vecs[i].s, vecs[i].b)));
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", i), {62'h0, done, busy}, 64'h0);
      last_exp = vecs[i].exp;
    end

    // Starts during CALC are ignored; result holds through the new CALC.
    ra = 32'h00001234; rb = 32'h80000003;
    start_mult = 1'b1; mult_sign = 1'b0; op_a = ra; op_b = rb;
    @(posedge clk); #1;
    start_mult = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      if (lat == 5 || lat == 20) begin
        start_mult = 1'b1; mult_sign = 1'b1; op_a = $urandom; op_b = $urandom;
      end else begin
        start_mult = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (lat == 10) check("hold_prod_in_calc", {prod_hi, prod_lo}, last_exp);
    end
    start_mult = 1'b0;
    check("ignore_start_prod", {prod_hi, prod_lo}, ref_prod(1'b0, ra, rb));
    check("ignore_start_lat", 64'(lat), 64'd33);
    @(posedge clk); #1;
    check("ignore_start_not_queued", {62'h0, done, busy}, 64'h0);

    // Back-to-back: start accepted in DONE.
    run_mult(1'b0, 32'h0000FFFF, 32'h80000001, lat, prod);
    check("b2b_first_prod", prod, ref_prod(1'b0, 32'h0000FFFF, 32'h80000001));
    run_mult(1'b1, 32'h80000001, 32'h7FFFFFFF, lat, prod);
    check("b2b_second_prod", prod, ref_prod(1'b1, 32'h80000001, 32'h7FFFFFFF));
    check("b2b_second_lat", 64'(lat), 64'(exp_lat(1'b1, 32'h7FFFFFFF)));
    @(posedge clk); #1;

    // Reset in the middle of CALC.
    start_mult = 1'b1; mult_sign = 1'b0; op_a = 32'h12345678; op_b = 32'h87654321;
    @(posedge clk); #1;
    start_mult = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("pre_reset_busy", {63'h0, busy}, 64'h1);
    reset = 1'b0;
    start_mult = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    start_mult = 1'b0;
    check("midreset_busy", {63'h0, busy}, 64'h0);
    check("midreset_done", {63'h0, done}, 64'h0);
    check("midreset_prod", {prod_hi, prod_lo}, 64'h0);
    @(posedge clk); #1;
    check("midreset_stays_idle", {62'h0, done, busy}, 64'h0);
    run_mult(1'b0, 32'd7, 32'd6, lat, prod);
    check("after_reset_7x6", prod, 64'h2A);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (i % 5 == 0) rb = -rb;
      run_mult(rs, ra, rb, lat, prod);
      check($sformatf("rand%0d_prod a=%h b=%h s=%0d", i, ra, rb, rs), prod,
            ref_prod(rs, ra, rb));
      check($sformatf("rand%0d_lat", i), 64'(lat), 64'(exp_lat(rs, rb)));
      if (i % 2 == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
